// File: rtl/tick_pkg.sv
// Shared types and default sizing for the tick scheduler and its channels.
package tick_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DIV_W  = 16;
  localparam int CH_IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RUN,
    ST_PEND
  } tick_state_e;

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: programmable divide-by-div tick pulse and square wave,
// with a shadow divisor that is applied at the next period boundary or sync.
module tick_channel
  import tick_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic             sync,
  output logic             tick,
  output logic             tog,
  output logic             busy
);

  tick_state_e      state, state_d;
  logic [DIV_W-1:0] count, count_d;
  logic [DIV_W-1:0] div, div_d;
  logic [DIV_W-1:0] shadow, shadow_d;
  logic             tick_d, tog_d;
  logic             wrap;

  // div is zero only in OFF, so the subtraction never underflows when it matters.
  assign wrap = (div != '0) && (count == div - DIV_W'(1));
  assign busy = (state == ST_PEND);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d  = state;
    count_d  = count;
    div_d    = div;
    shadow_d = shadow;
    tick_d   = 1'b0;
    tog_d    = tog;

    if (sync) begin
      count_d = '0;
      tog_d   = 1'b0;
      if (state == ST_PEND) begin
        div_d   = shadow;
        state_d = (shadow != '0) ? ST_RUN : ST_OFF;
      end
      // A config landing with sync behaves as if it arrived just after it.
      if (load) begin
        div_d   = load_div;
        state_d = (load_div != '0) ? ST_RUN : ST_OFF;
      end
    end else begin
      case (state)
        ST_OFF: begin
          if (load && (load_div != '0)) begin
            div_d   = load_div;
            count_d = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN, ST_PEND: begin
          if (wrap) begin
            count_d = '0;
            tick_d  = 1'b1;
            tog_d   = ~tog;
            if (state == ST_PEND) begin
              div_d = shadow;
              if (shadow == '0) begin
                state_d = ST_OFF;
                tog_d   = 1'b0;
              end else begin
                state_d = ST_RUN;
              end
            end
          end else begin
            count_d = count + DIV_W'(1);
          end
          if ((state == ST_RUN) && load) begin
            shadow_d = load_div;
            state_d  = ST_PEND;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_OFF;
      count  <= '0;
      div    <= '0;
      shadow <= '0;
      tick   <= 1'b0;
      tog    <= 1'b0;
    end else begin
      state  <= state_d;
      count  <= count_d;
      div    <= div_d;
      shadow <= shadow_d;
      tick   <= tick_d;
      tog    <= tog_d;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable scheduler: decodes the config port onto NUM_CH
// tick_channel instances and fans sync out to all of them.
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                sync,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   tog,
  output logic [NUM_CH-1:0]   busy
);

  logic [NUM_CH-1:0] load;

  // Out-of-range channel indices fall through with ready high and no load.
  always_comb begin
    cfg_ready = 1'b1;
    load      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_IDX_W'(i)) begin
        cfg_ready = ~busy[i];
        load[i]   = cfg_valid & ~busy[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[g]),
      .load_div(cfg_div),
      .sync    (sync),
      .tick    (tick[g]),
      .tog     (tog[g]),
      .busy    (busy[g])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: per-cycle vector tables with
// hand-derived expectations, queued at drive time and compared after the edge.
module tb_tick_scheduler;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              sync;
  logic [NUM_CH-1:0] tick, tog, busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic             valid;
    logic [2:0]       ch;
    logic [DIV_W-1:0] div;
    logic             sync;
    logic [3:0]       tick;
    logic [3:0]       tog;
    logic [3:0]       busy;
    logic             ready;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[17];

  tick_scheduler #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .sync     (sync),
    .tick     (tick),
    .tog      (tog),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input int ch, input int d, input logic s,
                              input logic [3:0] tk, input logic [3:0] tg,
                              input logic [3:0] bz, input logic r);
    vec_t x;
    x.valid = v;
    x.ch    = 3'(ch);
    x.div   = 16'(d);
    x.sync  = s;
    x.tick  = tk;
    x.tog   = tg;
    x.busy  = bz;
    x.ready = r;
    return x;
  endfunction

  function automatic vec_t idle(input logic [3:0] tk, input logic [3:0] tg,
                                input logic [3:0] bz, input logic r);
    return mk(1'b0, 0, 0, 1'b0, tk, tg, bz, r);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, check combinational ready before the edge,
  // queue the post-edge expectation and compare it after the edge.
  task automatic apply(input string name, input vec_t v);
    vec_t e;
    @(negedge clk);
    cfg_valid = v.valid;
    cfg_ch    = v.ch;
    cfg_div   = v.div;
    sync      = v.sync;
    #1;
    check({name, " ready"}, {3'b000, cfg_ready}, {3'b000, v.ready});
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({name, " tick"}, tick, e.tick);
    check({name, " tog"},  tog,  e.tog);
    check({name, " busy"}, busy, e.busy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    sync      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    sync      = 1'b0;
    #1;
    check("reset ready", {3'b000, cfg_ready}, 4'b0001);
    check("reset tick", tick, 4'b0000);
    check("reset busy", busy, 4'b0000);
    do_reset();

    // ch0 div=3 ticks every 3 cycles; ch1 div=4 retimed to div=2 mid-period.
    tbl[0]  = mk(1'b1, 0, 3, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    tbl[1]  = idle(4'b0000, 4'b0000, 4'b0000, 1'b1);
    tbl[2]  = idle(4'b0000, 4'b0000, 4'b0000, 1'b1);
    tbl[3]  = idle(4'b0001, 4'b0001, 4'b0000, 1'b1);
    tbl[4]  = mk(1'b1, 1, 4, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    tbl[5]  = idle(4'b0000, 4'b0001, 4'b0000, 1'b1);
    tbl[6]  = idle(4'b0001, 4'b0000, 4'b0000, 1'b1);
    tbl[7]  = idle(4'b0000, 4'b0000, 4'b0000, 1'b1);
    tbl[8]  = idle(4'b0010, 4'b0010, 4'b0000, 1'b1);
    tbl[9]  = mk(1'b1, 1, 2, 1'b0, 4'b0001, 4'b0011, 4'b0010, 1'b1);
    tbl[10] = mk(1'b0, 1, 0, 1'b0, 4'b0000, 4'b0011, 4'b0010, 1'b0);
    tbl[11] = mk(1'b0, 1, 0, 1'b0, 4'b0000, 4'b0011, 4'b0010, 1'b0);
    tbl[12] = idle(4'b0011, 4'b0000, 4'b0000, 1'b1);
    tbl[13] = idle(4'b0000, 4'b0000, 4'b0000, 1'b1);
    tbl[14] = idle(4'b0010, 4'b0010, 4'b0000, 1'b1);
    tbl[15] = idle(4'b0001, 4'b0011, 4'b0000, 1'b1);
    tbl[16] = idle(4'b0010, 4'b0001, 4'b0000, 1'b1);
    for (int i = 0; i < 17; i++) apply($sformatf("tbl[%0d]", i), tbl[i]);

    // Second request to a PEND channel stalls; another channel proceeds.
    do_reset();
    apply("stall0", mk(1'b1, 2, 4, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1));
    apply("stall1", mk(1'b1, 2, 3, 1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b1));
    apply("stall2", mk(1'b1, 2, 5, 1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b0));
    apply("stall3", mk(1'b1, 3, 2, 1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b1));
    apply("stall4", mk(1'b1, 2, 5, 1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0));
    apply("stall5", mk(1'b1, 2, 5, 1'b0, 4'b1000, 4'b1100, 4'b0100, 1'b1));

    // div=1 runs continuously; sync restarts every channel's count and phase.
    do_reset();
    apply("sync0", mk(1'b1, 0, 1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1));
    apply("sync1", mk(1'b1, 1, 5, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1));
    apply("sync2", idle(4'b0001, 4'b0000, 4'b0000, 1'b1));
    apply("sync3", idle(4'b0001, 4'b0001, 4'b0000, 1'b1));
    apply("sync4", mk(1'b0, 0, 0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1));
    apply("sync5", idle(4'b0001, 4'b0001, 4'b0000, 1'b1));
    apply("sync6", idle(4'b0001, 4'b0000, 4'b0000, 1'b1));
    apply("sync7", idle(4'b0001, 4'b0001, 4'b0000, 1'b1));
    apply("sync8", idle(4'b0001, 4'b0000, 4'b0000, 1'b1));
    apply("sync9", idle(4'b0011, 4'b0011, 4'b0000, 1'b1));

    // div=0 shuts a channel down at its wrap; out-of-range index is dropped;
    // cfg together with sync loads immediately.
    do_reset();
    apply("off0", mk(1'b1, 0, 2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1));
    apply("off1", mk(1'b1, 0, 0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1));
    apply("off2", idle(4'b0001, 4'b0000, 4'b0000, 1'b0));
    apply("off3", mk(1'b1, 6, 5, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1));
    apply("off4", idle(4'b0000, 4'b0000, 4'b0000, 1'b1));
    apply("off5", idle(4'b0000, 4'b0000, 4'b0000, 1'b1));
    apply("off6", mk(1'b1, 1, 2, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1));
    apply("off7", idle(4'b0000, 4'b0000, 4'b0000, 1'b1));
    apply("off8", idle(4'b0010, 4'b0010, 4'b0000, 1'b1));

    // Asynchronous reset mid-period with a shadow pending.
    do_reset();
    apply("rst0", mk(1'b1, 1, 1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1));
    apply("rst1", mk(1'b1, 0, 4, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1));
    apply("rst2", mk(1'b1, 0, 2, 1'b0, 4'b0010, 4'b0000, 4'b0001, 1'b1));
    apply("rst3", idle(4'b0010, 4'b0010, 4'b0001, 1'b0));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async rst tick",  tick, 4'b0000);
    check("async rst tog",   tog,  4'b0000);
    check("async rst busy",  busy, 4'b0000);
    check("async rst ready", {3'b000, cfg_ready}, 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst0", idle(4'b0000, 4'b0000, 4'b0000, 1'b1));
    apply("post_rst1", idle(4'b0000, 4'b0000, 4'b0000, 1'b1));

    check("queue drained", 4'(exp_q.size()), 4'b0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
